// File: rtl/gs232c_jtb_pkg.sv
// gs232c_jtb_pkg -- shared types for the indirect-jump target buffer.
//
// Contents:
//   jtb_entry_t : one table entry {valid, tag, target, conf}
//   qptr_t      : prediction queue pointer (queue depth up to 8)
//   qcnt_t      : prediction queue occupancy (0..8)
//   conf_sat_inc: saturating confidence increment
//
// Optional feature macro: GS232C_JTB_CONF_EN adds the 2-bit confidence
// counter to every entry. Without it, entries carry no confidence state.
//
// The tag field is sized for the widest tag a 32-bit PC can supply; the
// table module zero-fills the bits above its TAGW parameter, so those
// flops are constant and drop out.
package gs232c_jtb_pkg;

  localparam int TGTW     = 30;
  localparam int TAG_MAXW = 30;
  localparam int CONFW    = 2;
  localparam int QPTRW    = 3;

  typedef logic [QPTRW-1:0] qptr_t;
  typedef logic [QPTRW:0]   qcnt_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_MAXW-1:0] tag;
    logic [TGTW-1:0]     target;
`ifdef GS232C_JTB_CONF_EN
    logic [CONFW-1:0]    conf;
`endif
  } jtb_entry_t;

  function automatic logic [CONFW-1:0] conf_sat_inc(input logic [CONFW-1:0] c);
    return (c == '1) ? c : c + CONFW'(1);
  endfunction

endpackage

// File: rtl/gs232c_sel_first_field.sv
// gs232c_sel_first_field -- picks the field of the lowest-numbered set bit.
//
// Ports:
//   mask_i   [N]    : candidate slots
//   fields_i [N][W] : one field per slot
//   found_o         : at least one mask bit set
//   field_o  [W]    : field of the lowest set mask bit ('0 when none)
module gs232c_sel_first_field #(
  parameter int N = 4,
  parameter int W = 31
) (
  input  logic [N-1:0]        mask_i,
  input  logic [N-1:0][W-1:0] fields_i,
  output logic                found_o,
  output logic [W-1:0]        field_o
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    found_o = 1'b0;
    field_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        found_o = 1'b1;
        field_o = fields_i[i];
      end
    end
  end

endmodule

// File: rtl/gs232c_jtb_pq.sv
// gs232c_jtb_pq -- indirect-jump target buffer with a prediction queue.
//
// A lookup (pc_go) reads FW consecutive table entries starting at the
// index of bt_pc, registers the per-slot hit/target result, and pushes it
// into a BUFD-deep queue on the following cycle. The queue head, masked
// by o_jrops (lowest set bit wins), drives the prediction.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   bt_pc, pc_go            : lookup PC and lookup strobe
//   iq_go                   : pop queue head (ignored when empty)
//   pr_cancel / buf_cancel  : keep only head / flush whole queue
//   br_cancel, br_jrop      : redirect by an indirect jump -> table write
//   br_ok                   : indirect jump retired correctly predicted
//   br_pc, br_target        : branch PC and resolved target
//   jhr_last_br/jhr_last_pr : last-target history (branch / predict view)
//   o_jrops                 : jump-slot mask of the head group
//   o_target, o_hit         : prediction and whether it came from the table
//   buf_full                : queue holds BUFD groups
//   init_busy               : table clear sequencer running
//
// Handshake: pc_go and iq_go are single-cycle strobes; there is no ready
// back-pressure. A result arriving while the queue is full is dropped.
//
// Optional feature macro: GS232C_JTB_CONF_EN enables per-entry confidence
// counters (mispredict hysteresis and br_ok reinforcement). Without it,
// every indirect-jump redirect rewrites the entry and br_ok is ignored.
module gs232c_jtb_pq
  import gs232c_jtb_pkg::*;
#(
  parameter int FW      = 4,
  parameter int ENTRIES = 16,
  parameter int TAGW    = 9,
  parameter int BUFD    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   bt_pc,
  input  logic          pc_go,
  input  logic          iq_go,
  input  logic          pr_cancel,
  input  logic          buf_cancel,
  input  logic          br_cancel,
  input  logic          br_jrop,
  input  logic          br_ok,
  input  logic [31:0]   br_pc,
  input  logic [31:0]   br_target,
  input  logic [29:0]   jhr_last_br,
  input  logic [29:0]   jhr_last_pr,
  input  logic [FW-1:0] o_jrops,
  output logic [29:0]   o_target,
  output logic          o_hit,
  output logic          buf_full,
  output logic          init_busy
);

  localparam int IDXW  = $clog2(ENTRIES);
  localparam int TAGLO = IDXW + 2;
  localparam int PW    = $clog2(BUFD);

  function automatic logic [TAG_MAXW-1:0] tag_of(input logic [31:0] pc);
    logic [TAG_MAXW-1:0] t;
    t = '0;
    t[TAGW-1:0] = pc[TAGLO +: TAGW];
    return t;
  endfunction

  function automatic qptr_t ptr_inc(input qptr_t p);
    return (p + qptr_t'(1)) & qptr_t'(BUFD - 1);
  endfunction

  // ---------------- table and init sequencer ----------------
  jtb_entry_t       table_q [ENTRIES];
  logic             init_busy_q, init_busy_d;
  logic [IDXW-1:0]  init_idx_q, init_idx_d;

  always_comb begin
    init_busy_d = init_busy_q;
    init_idx_d  = init_idx_q;
    if (reset) begin
      init_busy_d = 1'b1;
      init_idx_d  = '0;
    end else if (init_busy_q) begin
      init_idx_d = init_idx_q + IDXW'(1);
      if (init_idx_q == IDXW'(ENTRIES - 1)) init_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    init_busy_q <= init_busy_d;
    init_idx_q  <= init_idx_d;
  end

  assign init_busy = init_busy_q;

  // ---------------- lookup (old contents on same-cycle update) ----------------
  logic [IDXW-1:0]          lk_idx;
  logic [TAG_MAXW-1:0]      lk_tag;
  logic [FW-1:0]            lk_hit;
  logic [FW-1:0][TGTW-1:0]  lk_tgt;

  assign lk_idx = bt_pc[IDXW+1:2];
  assign lk_tag = tag_of(bt_pc);

  for (genvar g = 0; g < FW; g++) begin : g_slot
    logic [IDXW:0] slot;
    jtb_entry_t    e;
    // The extra top bit flags slots past the last entry: they never hit.
    assign slot      = {1'b0, lk_idx} + (IDXW + 1)'(g);
    assign e         = table_q[slot[IDXW-1:0]];
    assign lk_hit[g] = ~slot[IDXW] & e.valid & (e.tag == lk_tag) & ~init_busy_q;
    assign lk_tgt[g] = e.target;
`ifdef GS232C_JTB_CONF_EN
    logic unused_conf;
    assign unused_conf = ^e.conf;
`endif
  end

  // ---------------- update ----------------
  logic [IDXW-1:0]      u_idx;
  logic [TAG_MAXW-1:0]  u_tag;
  jtb_entry_t           u_e, u_new;
  logic                 u_thit, u_we;

  assign u_idx  = br_pc[IDXW+1:2];
  assign u_tag  = tag_of(br_pc);
  assign u_e    = table_q[u_idx];
  assign u_thit = u_e.valid && (u_e.tag == u_tag);

  always_comb begin
    u_we         = 1'b0;
    u_new        = '0;
    // A target equal to the history already predicts itself; store invalid.
    u_new.valid  = (br_target[31:2] != jhr_last_br);
    u_new.tag    = u_tag;
    u_new.target = br_target[31:2];
`ifdef GS232C_JTB_CONF_EN
    u_new.conf   = CONFW'(1);
`endif
    if (!reset && !init_busy_q) begin
      if (br_cancel) begin
        if (br_jrop) begin
          u_we = 1'b1;
`ifdef GS232C_JTB_CONF_EN
          // A confident entry survives one mispredict with confidence lost.
          if (u_thit && (u_e.conf != '0)) begin
            u_new      = u_e;
            u_new.conf = u_e.conf - CONFW'(1);
          end
`endif
        end
      end
`ifdef GS232C_JTB_CONF_EN
      else if (br_ok && u_thit) begin
        u_we       = 1'b1;
        u_new      = u_e;
        u_new.conf = conf_sat_inc(u_e.conf);
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && init_busy_q) table_q[init_idx_q] <= '0;
    else if (u_we)             table_q[u_idx]      <= u_new;
  end

  // ---------------- read stage ----------------
  logic                    rd_v_q;
  logic [FW-1:0]           rd_hit_q;
  logic [FW-1:0][TGTW-1:0] rd_tgt_q;

  always_ff @(posedge clock) begin
    if (reset) rd_v_q <= 1'b0;
    else       rd_v_q <= pc_go;
    if (pc_go) begin
      rd_hit_q <= lk_hit;
      rd_tgt_q <= lk_tgt;
    end
  end

  // ---------------- prediction queue ----------------
  qptr_t head_q, head_d, tail_q, tail_d, head_pop;
  qcnt_t cnt_q, cnt_d, cnt_pop;
  logic  pop, push;
  logic [FW-1:0]           qh_q [BUFD];
  logic [FW-1:0][TGTW-1:0] qt_q [BUFD];

  assign pop      = iq_go && (cnt_q != '0);
  assign cnt_pop  = cnt_q - qcnt_t'(pop);
  assign head_pop = pop ? ptr_inc(head_q) : head_q;

  // Order within a cycle: pop, then cancel, then push of the read stage.
  always_comb begin
    head_d = head_pop;
    tail_d = tail_q;
    cnt_d  = cnt_pop;
    push   = 1'b0;
    if (buf_cancel) begin
      cnt_d  = '0;
      tail_d = head_pop;
    end else if (pr_cancel) begin
      if (pop || (cnt_q == '0)) begin
        cnt_d  = '0;
        tail_d = head_pop;
      end else begin
        cnt_d  = qcnt_t'(1);
        tail_d = ptr_inc(head_q);
      end
    end else if (rd_v_q && (cnt_pop != qcnt_t'(BUFD))) begin
      push   = 1'b1;
      tail_d = ptr_inc(tail_q);
      cnt_d  = cnt_pop + qcnt_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
    if (push) begin
      qh_q[tail_q[PW-1:0]] <= rd_hit_q;
      qt_q[tail_q[PW-1:0]] <= rd_tgt_q;
    end
  end

  assign buf_full = (cnt_q == qcnt_t'(BUFD));

  // ---------------- head slot selection ----------------
  logic [FW-1:0][TGTW:0] head_fields;
  logic                  sel_found;
  logic [TGTW:0]         sel_field;

  always_comb begin
    for (int i = 0; i < FW; i++)
      head_fields[i] = {qh_q[head_q[PW-1:0]][i], qt_q[head_q[PW-1:0]][i]};
  end

  gs232c_sel_first_field #(.N(FW), .W(TGTW + 1)) u_sel (
    .mask_i   (o_jrops),
    .fields_i (head_fields),
    .found_o  (sel_found),
    .field_o  (sel_field)
  );

  assign o_hit    = sel_found && sel_field[TGTW] && (cnt_q != '0);
  assign o_target = o_hit ? sel_field[TGTW-1:0] : jhr_last_pr;

  logic unused_bits;
  assign unused_bits = ^{bt_pc, br_pc, br_target[1:0], br_ok, u_e};

endmodule

// File: tb/tb_gs232c_jtb_pq.sv
module tb_gs232c_jtb_pq;

  localparam int FW = 4, ENTRIES = 16, TAGW = 9, BUFD = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b0;
  logic [31:0]   bt_pc = '0;
  logic          pc_go = 1'b0, iq_go = 1'b0, pr_cancel = 1'b0, buf_cancel = 1'b0;
  logic          br_cancel = 1'b0, br_jrop = 1'b0, br_ok = 1'b0;
  logic [31:0]   br_pc = '0, br_target = '0;
  logic [29:0]   jhr_last_br = '0, jhr_last_pr = '0;
  logic [FW-1:0] o_jrops = '0;
  logic [29:0]   o_target;
  logic          o_hit, buf_full, init_busy;

  gs232c_jtb_pq #(.FW(FW), .ENTRIES(ENTRIES), .TAGW(TAGW), .BUFD(BUFD)) dut (
    .clock(clock), .reset(reset), .bt_pc(bt_pc), .pc_go(pc_go), .iq_go(iq_go),
    .pr_cancel(pr_cancel), .buf_cancel(buf_cancel), .br_cancel(br_cancel),
    .br_jrop(br_jrop), .br_ok(br_ok), .br_pc(br_pc), .br_target(br_target),
    .jhr_last_br(jhr_last_br), .jhr_last_pr(jhr_last_pr), .o_jrops(o_jrops),
    .o_target(o_target), .o_hit(o_hit), .buf_full(buf_full), .init_busy(init_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [FW-1:0]        hit;
    logic [FW-1:0][29:0]  tgt;
  } grp_t;

  bit          m_valid [ENTRIES];
  logic [8:0]  m_tag   [ENTRIES];
  logic [29:0] m_tgt   [ENTRIES];
  int          m_conf  [ENTRIES];
  int          m_busy_left = 0;
  bit          m_live = 0;
  bit          m_rdv = 0;
  grp_t        m_rd;
  grp_t        exp_q [$];   // expected prediction queue contents

  task automatic model_step();
    grp_t g;
    bit   popped;
    int   ui;
    bit   thit;
    if (reset) begin
      m_live = 1; m_busy_left = ENTRIES; m_rdv = 0; exp_q.delete();
      return;
    end
    if (!m_live) return;
    g = '0;
    if (pc_go) begin
      for (int i = 0; i < FW; i++) begin
        int s;
        s = int'(bt_pc[5:2]) + i;
        if (s < ENTRIES) begin
          g.tgt[i] = m_tgt[s];
          g.hit[i] = m_valid[s] && (m_tag[s] == bt_pc[14:6]) && (m_busy_left == 0);
        end
      end
    end
    if (m_busy_left > 0) begin
      ui = ENTRIES - m_busy_left;
      m_valid[ui] = 0; m_tag[ui] = '0; m_tgt[ui] = '0; m_conf[ui] = 0;
      m_busy_left--;
    end else begin
      ui = int'(br_pc[5:2]);
      thit = m_valid[ui] && (m_tag[ui] == br_pc[14:6]);
      if (br_cancel && br_jrop) begin
`ifdef GS232C_JTB_CONF_EN
        if (thit && m_conf[ui] > 0) m_conf[ui]--;
        else begin
`else
        begin
`endif
          m_valid[ui] = (br_target[31:2] != jhr_last_br);
          m_tag[ui]   = br_pc[14:6];
          m_tgt[ui]   = br_target[31:2];
          m_conf[ui]  = 1;
        end
      end
`ifdef GS232C_JTB_CONF_EN
      else if (!br_cancel && br_ok && thit && m_conf[ui] < 3) m_conf[ui]++;
`endif
    end
    popped = iq_go && exp_q.size() > 0;
    if (popped) void'(exp_q.pop_front());
    if (buf_cancel) exp_q.delete();
    else if (pr_cancel) begin
      if (popped) exp_q.delete();
      else while (exp_q.size() > 1) void'(exp_q.pop_back());
    end else if (m_rdv && exp_q.size() < BUFD) exp_q.push_back(m_rd);
    m_rdv = pc_go;
    if (pc_go) m_rd = g;
  endtask

  task automatic compare();
    logic        eh;
    logic [29:0] et;
    if (!m_live) return;
    eh = 1'b0;
    et = jhr_last_pr;
    if (exp_q.size() > 0) begin
      for (int i = FW - 1; i >= 0; i--)
        if (o_jrops[i]) begin
          eh = exp_q[0].hit[i];
          et = exp_q[0].hit[i] ? exp_q[0].tgt[i] : jhr_last_pr;
        end
    end
    chk("o_hit", o_hit, eh);
    chk("o_target", o_target, et);
    chk("buf_full", buf_full, exp_q.size() == BUFD);
    chk("init_busy", init_busy, m_busy_left > 0);
  endtask

  task automatic tick();
    #1;
    compare();
    model_step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt);
    br_cancel = 1; br_jrop = 1; br_pc = pc; br_target = tgt;
    tick();
    br_cancel = 0; br_jrop = 0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    buf_cancel = 1; tick(); buf_cancel = 0;
    bt_pc = pc; pc_go = 1; tick(); pc_go = 0; tick();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (init_busy && n < 40) begin tick(); n++; end
    chk(name, n, 16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    o_jrops = 4'b0010;
    jhr_last_pr = 30'h155;

    // Reset and init timing, lookup while clearing.
    reset = 1; tick(); reset = 0;
    chk("busy_after_reset", init_busy, 1);
    bt_pc = 32'h1000; pc_go = 1; tick(); pc_go = 0; tick();
    chk("hit_during_busy", o_hit, 0);
    n = 2;
    while (init_busy && n < 40) begin tick(); n++; end
    chk("init_cycles", n, 16);

    // Write one entry, look it up from the group base one slot below.
    jhr_last_br = '0;
    do_update(32'h1004, 32'h8000);
    do_lookup(32'h1000);
    chk("upd_hit", o_hit, 1);
    chk("upd_target", o_target, 30'h2000);
    o_jrops = 4'b0001; #1;
    chk("slot0_miss", o_hit, 0);
    chk("slot0_tgt", o_target, 30'h155);
    o_jrops = 4'b0010;

    // Mispredict hysteresis.
    do_update(32'h1004, 32'h9000);
    do_lookup(32'h1000);
`ifdef GS232C_JTB_CONF_EN
    chk("mis1_target", o_target, 30'h2000);
`else
    chk("mis1_target", o_target, 30'h2400);
`endif
    do_update(32'h1004, 32'h9000);
    do_lookup(32'h1000);
    chk("mis2_target", o_target, 30'h2400);

    // Queue overflow: third group dropped.
    buf_cancel = 1; tick(); buf_cancel = 0;
    bt_pc = 32'h1000; pc_go = 1; tick(); tick(); tick(); pc_go = 0; tick(); tick();
    chk("full_after_3", buf_full, 1);
    iq_go = 1; tick();
    chk("full_after_pop", buf_full, 0);
    chk("hit_one_left", o_hit, 1);
    tick(); iq_go = 0;
    chk("hit_empty", o_hit, 0);
    chk("tgt_empty", o_target, 30'h155);

    // pr_cancel keeps head; buf_cancel with iq_go empties.
    pc_go = 1; tick(); tick(); pc_go = 0; tick(); tick();
    chk("two_queued", buf_full, 1);
    pr_cancel = 1; tick(); pr_cancel = 0;
    chk("pr_keep_full", buf_full, 0);
    chk("pr_keep_hit", o_hit, 1);
    iq_go = 1; tick(); iq_go = 0;
    chk("pr_left_one", o_hit, 0);
    pc_go = 1; tick(); pc_go = 0; tick(); tick();
    buf_cancel = 1; iq_go = 1; tick(); buf_cancel = 0; iq_go = 0;
    jhr_last_pr = 30'h3ABCD; #1;
    chk("bc_hit", o_hit, 0);
    chk("bc_target", o_target, 30'h3ABCD);

    // Reset mid-init restarts the sequence and clears the table.
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1; tick(); reset = 0;
    wait_init("restart_cycles");
    do_lookup(32'h1000);
    chk("cleared_miss", o_hit, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      bt_pc = ($urandom & 32'hFFFF8003) | (32'(9'h40 + $urandom_range(0, 1)) << 6)
              | (32'($urandom_range(0, 15)) << 2);
      br_pc = (32'(9'h40 + $urandom_range(0, 1)) << 6) | (32'($urandom_range(0, 15)) << 2);
      br_target = $urandom;
      jhr_last_br = ($urandom_range(0, 3) == 0) ? br_target[31:2] : 30'($urandom);
      jhr_last_pr = 30'($urandom);
      o_jrops     = 4'($urandom);
      pc_go       = r[0];
      iq_go       = ($urandom_range(0, 9) < 4);
      br_cancel   = ($urandom_range(0, 99) < 15);
      br_jrop     = ($urandom_range(0, 9) < 7);
      br_ok       = ($urandom_range(0, 9) < 3);
      pr_cancel   = ($urandom_range(0, 99) < 4);
      buf_cancel  = ($urandom_range(0, 99) < 4);
      reset       = ($urandom_range(0, 999) < 3);
      tick();
    end
    reset = 0; pc_go = 0; iq_go = 0; br_cancel = 0; br_ok = 0;
    pr_cancel = 0; buf_cancel = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
